fir_coeff_reload_ctrl: RTL and testbench

//  Controller in front of the low-pass FIR. Passes the DDS sample stream into the FIR sink in normal

---
 rtl/fir_coeff_reload_ctrl.sv | 143 ++++++++++++++
 tb/tb_fir_coeff_reload_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/fir_coeff_reload_ctrl.sv
// FIR coefficient reload controller: stream pass-through, ROM-to-tap reload, zero flush.
// Optional FIR_RELOAD_CKSUM_EN adds coef_sum, the running sum of accepted coefficients.
module fir_coeff_reload_ctrl #(
  parameter int DATA_W  = 8,
  parameter int COEF_W  = 12,
  parameter int TAP_AW  = 5,
  parameter int SET_W   = 2,
  parameter int FLUSH_N = 40
) (
  input  logic                    sclk,
  input  logic                    rst,
  input  logic                    reload_req,
  input  logic [SET_W-1:0]        reload_set,
  output logic                    reload_busy,
  output logic                    reload_done,
  output logic                    rom_rd,
  output logic [SET_W+TAP_AW-1:0] rom_addr,
  input  logic [COEF_W-1:0]       rom_data,
  output logic                    coeff_we,
  output logic [TAP_AW-1:0]       coeff_addr,
  output logic [COEF_W-1:0]       coeff_data,
  input  logic                    coeff_ready,
  input  logic [DATA_W-1:0]       src_data,
  input  logic                    src_valid,
  output logic                    src_ready,
  output logic [DATA_W-1:0]       sink_data,
  output logic                    sink_valid,
  input  logic                    sink_ready,
  input  logic                    lpf_valid_in,
  output logic                    lpf_valid_out
`ifdef FIR_RELOAD_CKSUM_EN
  ,
  output logic [COEF_W+TAP_AW-1:0] coef_sum
`endif
);

  localparam int FC_W = (FLUSH_N > 1) ? $clog2(FLUSH_N) : 1;

  typedef enum logic [2:0] {
    IDLE, RD, WR, FLUSH, DONE
  } state_t;

  state_t              state;
  logic [SET_W-1:0]    set_q;
  logic [TAP_AW-1:0]   tap;
  logic [FC_W-1:0]     fcnt;
  logic                mask;
  logic                wr_first;
  logic [COEF_W-1:0]   data_q;
  logic                idle;
  logic                accept;

  assign idle   = (state == IDLE);
  assign accept = coeff_we & coeff_ready;

  always_ff @(posedge sclk) begin
    if (rst) begin
      state       <= IDLE;
      reload_busy <= 1'b0;
      reload_done <= 1'b0;
      rom_rd      <= 1'b0;
      coeff_we    <= 1'b0;
      mask        <= 1'b0;
      wr_first    <= 1'b0;
      set_q       <= '0;
      tap         <= '0;
      fcnt        <= '0;
      data_q      <= '0;
    end else begin
      reload_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (reload_req) begin
            set_q       <= reload_set;
            tap         <= '0;
            mask        <= 1'b1;
            reload_busy <= 1'b1;
            rom_rd      <= 1'b1;
            state       <= RD;
          end
        end
        RD: begin
          rom_rd   <= 1'b0;
          coeff_we <= 1'b1;
          wr_first <= 1'b1;
          state    <= WR;
        end
        WR: begin
          // ROM data is only valid the cycle after the read; hold it for stalls
          wr_first <= 1'b0;
          if (wr_first) data_q <= rom_data;
          if (accept) begin
            coeff_we <= 1'b0;
            if (&tap) begin
              fcnt  <= '0;
              state <= FLUSH;
            end else begin
              tap    <= tap + 1'b1;
              rom_rd <= 1'b1;
              state  <= RD;
            end
          end
        end
        FLUSH: begin
          if (sink_ready) begin
            if (fcnt == FC_W'(FLUSH_N - 1)) begin
              reload_done <= 1'b1;
              mask        <= 1'b0;
              state       <= DONE;
            end else begin
              fcnt <= fcnt + 1'b1;
            end
          end
        end
        DONE: begin
          reload_busy <= 1'b0;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rom_addr      = {set_q, tap};
  assign coeff_addr    = tap;
  assign coeff_data    = wr_first ? rom_data : data_q;
  assign src_ready     = idle & sink_ready;
  assign sink_data     = idle ? src_data : '0;
  assign sink_valid    = idle ? src_valid : (state == FLUSH);
  assign lpf_valid_out = lpf_valid_in & ~mask;

`ifdef FIR_RELOAD_CKSUM_EN
  always_ff @(posedge sclk) begin
    if (rst)
      coef_sum <= '0;
    else if (idle && reload_req)
      coef_sum <= '0;
    else if (state == WR && accept)
      coef_sum <= coef_sum + (COEF_W+TAP_AW)'(coeff_data);
  end
`endif

endmodule

// File: tb/tb_fir_coeff_reload_ctrl.sv
// Randomized bench for fir_coeff_reload_ctrl against a transaction-level model.
// Build with FIR_RELOAD_CKSUM_EN to also check coef_sum.
module tb_fir_coeff_reload_ctrl;
  localparam int NT = 32;
  localparam int FLUSH_N = 40;

  logic        sclk = 1'b0;
  logic        rst;
  logic        reload_req;
  logic [1:0]  reload_set;
  logic        reload_busy, reload_done;
  logic        rom_rd;
  logic [6:0]  rom_addr;
  logic [11:0] rom_data;
  logic        coeff_we;
  logic [4:0]  coeff_addr;
  logic [11:0] coeff_data;
  logic        coeff_ready;
  logic [7:0]  src_data;
  logic        src_valid, src_ready;
  logic [7:0]  sink_data;
  logic        sink_valid, sink_ready;
  logic        lpf_valid_in, lpf_valid_out;
`ifdef FIR_RELOAD_CKSUM_EN
  logic [16:0] coef_sum;
`endif

  int total = 0;
  int bad = 0;
  logic [11:0] rom [128];

  fir_coeff_reload_ctrl dut (
    .sclk(sclk), .rst(rst),
    .reload_req(reload_req), .reload_set(reload_set),
    .reload_busy(reload_busy), .reload_done(reload_done),
    .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_data(rom_data),
    .coeff_we(coeff_we), .coeff_addr(coeff_addr),
    .coeff_data(coeff_data), .coeff_ready(coeff_ready),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .sink_data(sink_data), .sink_valid(sink_valid),
    .sink_ready(sink_ready),
    .lpf_valid_in(lpf_valid_in), .lpf_valid_out(lpf_valid_out)
`ifdef FIR_RELOAD_CKSUM_EN
    , .coef_sum(coef_sum)
`endif
  );

  always #5 sclk = ~sclk;

  always @(posedge sclk)
    if (rom_rd) rom_data <= rom[rom_addr];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, exp);
    end
  endtask

  task automatic rand_src();
    src_valid    = 1'($urandom);
    src_data     = 8'($urandom);
    lpf_valid_in = 1'($urandom);
  endtask

  task automatic check_pass(input string tag);
    chk({tag, "_busy"}, 32'(reload_busy), 0);
    chk({tag, "_sdata"}, 32'(sink_data), 32'(src_data));
    chk({tag, "_svld"}, 32'(sink_valid), 32'(src_valid));
    chk({tag, "_srdy"}, 32'(src_ready), 32'(sink_ready));
    chk({tag, "_lpf"}, 32'(lpf_valid_out), 32'(lpf_valid_in));
  endtask

  task automatic run_reload(input logic [1:0] s, input int pc,
                            input int ps, input bit abort10);
    int  cyc, tap, flushed, sum;
    bit  exp_rd, exp_we, done, aborted, acc;
    @(posedge sclk); #1;
    reload_req = 1'b1;
    reload_set = s;
    rand_src();
    @(posedge sclk); #1;
    reload_req = 1'b0;
    reload_set = 2'($urandom);
    tap = 0; flushed = 0; sum = 0; cyc = 1;
    exp_rd = 1; exp_we = 0; done = 0; aborted = 0;
    while (!done && cyc < 3000) begin
      coeff_ready = ($urandom_range(99) < pc);
      sink_ready  = ($urandom_range(99) < ps);
      rand_src();
      @(negedge sclk);
      if (reload_done) begin
        chk("done_taps", tap, NT);
        chk("done_flush", flushed, FLUSH_N);
        if (pc == 100 && ps == 100)
          chk("done_cyc", cyc, 1 + 2*NT + FLUSH_N);
`ifdef FIR_RELOAD_CKSUM_EN
        chk("cksum", 32'(coef_sum), sum % 131072);
`endif
        done = 1;
      end else begin
        chk("busy", 32'(reload_busy), 1);
        chk("src_rdy", 32'(src_ready), 0);
        chk("lpf_mask", 32'(lpf_valid_out), 0);
        chk("rom_rd", 32'(rom_rd), 32'(exp_rd));
        chk("coeff_we", 32'(coeff_we), 32'(exp_we));
        chk("sink_vld", 32'(sink_valid), 32'(tap == NT));
        if (rom_rd)
          chk("rom_addr", 32'(rom_addr), 32'({s, 5'(tap)}));
        acc = 0;
        if (coeff_we) begin
          chk("c_addr", 32'(coeff_addr), tap);
          chk("c_data", 32'(coeff_data), 32'(rom[{s, 5'(tap)}]));
          if (abort10 && tap == 10) aborted = 1;
          acc = coeff_ready;
        end
        if (sink_valid) begin
          chk("sink_zero", 32'(sink_data), 0);
          if (sink_ready) flushed++;
        end
        if (aborted) break;
        if (exp_rd) begin
          exp_rd = 0;
          exp_we = 1;
        end else if (acc) begin
          sum += int'(rom[{s, 5'(tap)}]);
          tap++;
          exp_we = 0;
          exp_rd = (tap < NT);
        end
      end
      cyc++;
      @(posedge sclk); #1;
    end
    if (aborted) begin
      @(posedge sclk); #1;
      rst = 1'b1;
      @(posedge sclk); #1;
      rst = 1'b0;
      sink_ready = 1'b1;
      rand_src();
      @(negedge sclk);
      chk("abort_we", 32'(coeff_we), 0);
      chk("abort_rd", 32'(rom_rd), 0);
      check_pass("abort");
    end else begin
      if (!done) chk("timeout", 0, 1);
      sink_ready = 1'b1;
      rand_src();
      @(negedge sclk);
      check_pass("after");
    end
  endtask

  initial begin
    rst = 1'b1; reload_req = 1'b0; reload_set = '0;
    coeff_ready = 1'b1; sink_ready = 1'b1;
    src_valid = 1'b0; src_data = '0; lpf_valid_in = 1'b1;
    rom_data = '0;
    for (int i = 0; i < 128; i++) rom[i] = 12'(i);
    repeat (2) @(posedge sclk);
    #1;
    rst = 1'b0;
    @(negedge sclk);
    chk("rst_busy", 32'(reload_busy), 0);
    chk("rst_done", 32'(reload_done), 0);
    chk("rst_rd", 32'(rom_rd), 0);
    chk("rst_we", 32'(coeff_we), 0);
    chk("rst_lpf", 32'(lpf_valid_out), 1);
`ifdef FIR_RELOAD_CKSUM_EN
    chk("rst_sum", 32'(coef_sum), 0);
`endif

    for (int i = 0; i < 256; i++) begin
      @(posedge sclk); #1;
      src_data     = 8'(i);
      src_valid    = 1'($urandom);
      sink_ready   = 1'($urandom);
      lpf_valid_in = 1'($urandom);
      @(negedge sclk);
      check_pass("pass");
    end

    run_reload(2'd2, 100, 100, 0);

    for (int i = 0; i < 128; i++) rom[i] = 12'($urandom);
    run_reload(2'd1, 60, 50, 0);
    run_reload(2'd0, 100, 50, 0);
    run_reload(2'd3, 70, 100, 1);
    run_reload(2'd3, 100, 100, 0);

`ifdef FIR_RELOAD_CKSUM_EN
    for (int i = 0; i < 128; i++) rom[i] = 12'hFFF;
    run_reload(2'd1, 80, 80, 0);
    chk("sum_fff", 32'(coef_sum), 131040);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
